// File: rtl/dm_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    MERGE
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [BE_W-1:0] BE_NONE = 4'h0;
  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

  // Request payload as latched on acceptance
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dm_byte_merge.sv
// Lane-wise merge of a new write word into an old memory word under byte enables.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) merged_c[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one synchronous-read word memory between the CPU
// load/store port (0) and the debug/loader port (1); sub-word stores become RMW.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned NMEM = 256,
  parameter int unsigned AW   = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_resp_valid,
  output logic          p0_resp_err,
  output logic [31:0]   p0_rdata,

  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_resp_valid,
  output logic          p1_resp_err,
  output logic [31:0]   p1_rdata,

  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic              gnt0, gnt1;
  logic              req_err, req_zero, req_full;
  logic [AW-1:0]     req_word;
  logic [DATA_W-1:0] merged;
  logic              resp_valid, resp_error;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        unused_addr_lsb;

  assign req_word        = req_q.addr[AW+1:2];
  assign req_err         = req_q.addr[31:2] >= 30'(NMEM);
  assign req_zero        = req_q.we && (req_q.be == BE_NONE);
  assign req_full        = req_q.we && (req_q.be == BE_FULL);
  assign unused_addr_lsb = req_q.addr[1:0];

  dm_byte_merge u_merge (
    .old_word (mem_rdata),
    .new_word (req_q.wdata),
    .be       (req_q.be),
    .merged_c (merged)
  );

  // Round-robin: on a tie the port that was not granted last wins
  always_comb begin
    gnt0 = p0_valid;
    gnt1 = p1_valid;
    if (p0_valid && p1_valid) begin
      gnt0 = (last_grant_q != PORT_CPU);
      gnt1 = (last_grant_q != PORT_DBG);
    end
    p0_ready = (state_q == IDLE) && !rst && gnt0;
    p1_ready = (state_q == IDLE) && !rst && gnt1;
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (p0_ready) begin
          req_d.we     = p0_we;
          req_d.be     = p0_be;
          req_d.addr   = p0_addr;
          req_d.wdata  = p0_wdata;
          owner_d      = PORT_CPU;
          last_grant_d = PORT_CPU;
          state_d      = ISSUE;
        end else if (p1_ready) begin
          req_d.we     = p1_we;
          req_d.be     = p1_be;
          req_d.addr   = p1_addr;
          req_d.wdata  = p1_wdata;
          owner_d      = PORT_DBG;
          last_grant_d = PORT_DBG;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (req_err || req_zero || req_full) state_d = IDLE;
        else if (!req_q.we)                  state_d = RD_WAIT;
        else                                 state_d = MERGE;
      end
      RD_WAIT: state_d = IDLE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_DBG;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs decode from the registered state; rst blanks them so a request
  // caught mid-flight never writes memory or responds
  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    resp_rdata = '0;
    if (!rst) begin
      case (state_q)
        ISSUE: begin
          if (req_err) begin
            resp_valid = 1'b1;
            resp_error = 1'b1;
          end else if (req_zero) begin
            resp_valid = 1'b1;
          end else if (req_full) begin
            mem_we     = 1'b1;
            mem_addr   = req_word;
            mem_wdata  = req_q.wdata;
            resp_valid = 1'b1;
          end else begin
            mem_re   = 1'b1;
            mem_addr = req_word;
          end
        end
        RD_WAIT: begin
          resp_valid = 1'b1;
          resp_rdata = mem_rdata;
        end
        MERGE: begin
          mem_we     = 1'b1;
          mem_addr   = req_word;
          mem_wdata  = merged;
          resp_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    p0_resp_valid = resp_valid && (owner_q == PORT_CPU);
    p0_resp_err   = resp_error && (owner_q == PORT_CPU);
    p0_rdata      = (owner_q == PORT_CPU) ? resp_rdata : '0;
    p1_resp_valid = resp_valid && (owner_q == PORT_DBG);
    p1_resp_err   = resp_error && (owner_q == PORT_DBG);
    p1_rdata      = (owner_q == PORT_DBG) ? resp_rdata : '0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus random traffic
// against a transaction-level memory model.
module tb_dm_arbiter;

  localparam int unsigned NMEM = 256;
  localparam int unsigned AW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p0_ready, p0_we, p0_resp_valid, p0_resp_err;
  logic [3:0]    p0_be;
  logic [31:0]   p0_addr, p0_wdata, p0_rdata;
  logic          p1_valid, p1_ready, p1_we, p1_resp_valid, p1_resp_err;
  logic [3:0]    p1_be;
  logic [31:0]   p1_addr, p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  dm_arbiter #(.NMEM(NMEM), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_err(p0_resp_err), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_err(p1_resp_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array attached to the DUT
  logic [31:0] mem [NMEM];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  logic [31:0] ref_mem [NMEM];
  logic        exp_last;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic rdy(input logic p);
    return p ? p1_ready : p0_ready;
  endfunction
  function automatic logic rv(input logic p);
    return p ? p1_resp_valid : p0_resp_valid;
  endfunction
  function automatic logic rerr(input logic p);
    return p ? p1_resp_err : p0_resp_err;
  endfunction
  function automatic logic [31:0] rd(input logic p);
    return p ? p1_rdata : p0_rdata;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (!p) begin
      p0_valid = v; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_valid = v; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(p0_ready), 32'h0);
    chk("rst_ready1", 32'(p1_ready), 32'h0);
    chk("rst_resp0", 32'(p0_resp_valid), 32'h0);
    chk("rst_resp1", 32'(p1_resp_valid), 32'h0);
    chk("rst_mem_strobes", 32'({mem_re, mem_we}), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_last = 1'b1;
  endtask

  // One complete request on port p; with tie=1 the other port also requests and p must win
  task automatic run_req(input logic p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic tie);
    logic          err;
    logic [AW-1:0] w;
    logic          exp_rdy;
    logic [31:0]   exp_w;
    err     = addr[31:2] >= 30'(NMEM);
    w       = addr[AW+1:2];
    exp_rdy = tie ? (exp_last != p) : 1'b1;
    set_req(p, 1'b1, we, be, addr, wdata);
    if (tie) set_req(!p, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ready_own", 32'(rdy(p)), 32'(exp_rdy));
    if (tie) chk("ready_other", 32'(rdy(!p)), 32'(!exp_rdy));
    @(posedge clk);
    exp_last = p;
    #1;
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("other_resp_t1", 32'(rv(!p)), 32'h0);
    if (err) begin
      chk("err_resp", 32'({rv(p), rerr(p)}), 32'h3);
      chk("err_no_mem", 32'({mem_re, mem_we}), 32'h0);
    end else if (we && be == 4'h0) begin
      chk("be0_resp", 32'({rv(p), rerr(p)}), 32'h2);
      chk("be0_no_mem", 32'({mem_re, mem_we}), 32'h0);
    end else if (we && be == 4'hF) begin
      chk("fullwr_resp", 32'({rv(p), rerr(p)}), 32'h2);
      chk("fullwr_strobes", 32'({mem_re, mem_we}), 32'h1);
      chk("fullwr_addr", 32'(mem_addr), 32'(w));
      chk("fullwr_data", mem_wdata, wdata);
      ref_mem[w] = wdata;
    end else begin
      chk("issue_resp", 32'(rv(p)), 32'h0);
      chk("issue_strobes", 32'({mem_re, mem_we}), 32'h2);
      chk("issue_addr", 32'(mem_addr), 32'(w));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("other_resp_t2", 32'(rv(!p)), 32'h0);
      chk("t2_resp", 32'({rv(p), rerr(p)}), 32'h2);
      if (!we) begin
        chk("rd_no_mem", 32'({mem_re, mem_we}), 32'h0);
        chk("rd_data", rd(p), ref_mem[w]);
      end else begin
        exp_w = lane_merge(ref_mem[w], wdata, be);
        chk("merge_strobes", 32'({mem_re, mem_we}), 32'h1);
        chk("merge_addr", 32'(mem_addr), 32'(w));
        chk("merge_data", mem_wdata, exp_w);
        ref_mem[w] = exp_w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          win;
    logic          rp, rwe;
    logic [3:0]    rbe;
    logic [31:0]   raddr;
    int            sel;

    do_reset();

    // Loader fills the low 32 words so later reads have known contents
    for (int i = 0; i < 32; i++) run_req(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);

    run_req(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    run_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("word4_written", ref_mem[4], 32'hDEADBEEF);
    run_req(1'b0, 1'b1, 4'b0001, 32'h10, 32'h000000AB, 1'b0);
    chk("word4_merged", mem[4], 32'hDEADBEAB);
    run_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);

    // Both ports continuously requesting reads after reset
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    for (int g = 0; g < 4; g++) begin
      win = (exp_last == 1'b1) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("rr_ready_win", 32'(rdy(win)), 32'h1);
      chk("rr_ready_lose", 32'(rdy(!win)), 32'h0);
      chk("rr_order", 32'(win), 32'(g % 2));
      @(posedge clk);
      exp_last = win;
      #1;
      @(negedge clk);
      chk("rr_busy_ready", 32'({p0_ready, p1_ready}), 32'h0);
      chk("rr_issue_re", 32'(mem_re), 32'h1);
      chk("rr_issue_resp", 32'({p0_resp_valid, p1_resp_valid}), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rr_resp_own", 32'(rv(win)), 32'h1);
      chk("rr_resp_other", 32'(rv(!win)), 32'h0);
      chk("rr_rdata", rd(win), ref_mem[16 + int'(win)]);
      @(posedge clk);
      #1;
    end
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    run_req(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0);
    run_req(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h12345678, 1'b0);
    run_req(1'b0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0);
    run_req(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);

    // Reset lands on the MERGE cycle of a partial write
    set_req(1'b0, 1'b1, 1'b1, 4'b0010, 32'h14, 32'h0000CD00);
    @(negedge clk);
    chk("rstm_ready", 32'(p0_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstm_issue_re", 32'(mem_re), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstm_no_we", 32'(mem_we), 32'h0);
    chk("rstm_no_resp", 32'({p0_resp_valid, p1_resp_valid}), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_last = 1'b1;
    run_req(1'b0, 1'b0, 4'h0, 32'h14, 32'h0, 1'b1);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      rp  = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      rbe = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
      if ($urandom_range(0, 9) == 0) raddr = 32'h400 + 32'($urandom_range(0, 65535));
      else                           raddr = 32'($urandom_range(0, 127));
      run_req(rp, rwe, rbe, raddr, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
